addsub_serial: RTL and testbench

- Parametrised, multi-cycle two's-complement adder/subtractor: the sequential successor of the team's 4-bit XOR-inverted add/sub datapath.
- Processes the operands CHUNK bits per clock through one ripple adder slice, so area scales with CHUNK rather than WIDTH.
- Uses valid/ready handshakes on both sides and reports carry, signed overflow, negative and zero flags.
- Sits between the operand register file and result writeback in the arithmetic path.

---
 rtl/addsub_serial.sv | 111 +++++++++++
 tb/tb_addsub_serial.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/addsub_serial.sv
// addsub_serial: multi-cycle two's-complement adder/subtractor, CHUNK bits per clock
//   Build option: define ADDSUB_SAT_EN to clamp o_s on signed overflow.
//   Ports:
//     i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//     i_valid / o_ready    operand handshake; i_a, i_b operands, i_sub (0 add, 1 subtract)
//     o_valid / i_ready    result handshake; o_s result
//     o_c carry out (1 = no borrow on subtract), o_v signed overflow,
//     o_n negative (o_s msb), o_z zero
module addsub_serial #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_c,
    output logic             o_v,
    output logic             o_n,
    output logic             o_z
);
    localparam int N  = WIDTH / CHUNK;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam int IW = $clog2(WIDTH);

    if (WIDTH < 2 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("addsub_serial: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_q, b_q, res, sum_full, s_fin;
    logic [CW-1:0]    cnt;
    logic [IW-1:0]    base;
    logic [CHUNK:0]   part;
    logic             cy, last, v_fin;

    assign o_ready = (state == IDLE);
    assign o_valid = (state == DONE);
    assign last    = (cnt == CW'(N - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = i_valid ? BUSY : IDLE;
            BUSY:    state_nxt = last ? DONE : BUSY;
            DONE:    state_nxt = i_ready ? IDLE : DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // One CHUNK-wide ripple slice; sum_full is the result with this cycle's chunk merged in,
    // so on the last cycle it holds the complete raw sum for the flag logic.
    always_comb begin
        base     = IW'(int'(cnt) * CHUNK);
        part     = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]} + (CHUNK + 1)'(cy);
        sum_full = res;
        sum_full[base +: CHUNK] = part[CHUNK-1:0];
        // b_q already holds the inverted operand, so its msb is b'_msb
        v_fin    = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_full[WIDTH-1] != a_q[WIDTH-1]);
`ifdef ADDSUB_SAT_EN
        s_fin    = v_fin ? {a_q[WIDTH-1], {(WIDTH-1){~a_q[WIDTH-1]}}} : sum_full;
`else
        s_fin    = sum_full;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q <= '0;
            b_q <= '0;
            res <= '0;
            cy  <= 1'b0;
            cnt <= '0;
            o_s <= '0;
            o_c <= 1'b0;
            o_v <= 1'b0;
            o_n <= 1'b0;
            o_z <= 1'b0;
        end else if (state == IDLE && i_valid) begin
            // subtraction as A + ~B + 1: the +1 enters through the initial carry
            a_q <= i_a;
            b_q <= i_b ^ {WIDTH{i_sub}};
            cy  <= i_sub;
            cnt <= '0;
        end else if (state == BUSY) begin
            res <= sum_full;
            cy  <= part[CHUNK];
            cnt <= cnt + CW'(1);
            if (last) begin
                o_s <= s_fin;
                o_c <= part[CHUNK];
                o_v <= v_fin;
                o_n <= s_fin[WIDTH-1];
                o_z <= (s_fin == '0);
            end
        end
    end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: directed scoreboard bench for addsub_serial (WIDTH=8, CHUNK=2)
module tb_addsub_serial;
    logic       clk = 1'b0;
    logic       rst_n, i_valid, i_sub, i_ready;
    logic [7:0] i_a, i_b;
    logic       o_ready, o_valid, o_c, o_v, o_n, o_z;
    logic [7:0] o_s;
    int         pass = 0, total = 0;

    typedef struct {
        logic [7:0] s;
        logic       c, v, n, z;
    } exp_t;

    exp_t sb[$];

    addsub_serial #(.WIDTH(8), .CHUNK(2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
        .i_a(i_a), .i_b(i_b), .i_sub(i_sub), .o_valid(o_valid), .i_ready(i_ready),
        .o_s(o_s), .o_c(o_c), .o_v(o_v), .o_n(o_n), .o_z(o_z)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic sub);
        exp_t       e;
        logic [7:0] bb;
        logic [8:0] full;
        bb   = b ^ {8{sub}};
        full = {1'b0, a} + {1'b0, bb} + 9'(sub);
        e.c  = full[8];
        e.v  = (a[7] == bb[7]) && (full[7] != a[7]);
        e.s  = full[7:0];
`ifdef ADDSUB_SAT_EN
        if (e.v) e.s = a[7] ? 8'h80 : 8'h7F;
`endif
        e.n  = e.s[7];
        e.z  = (e.s == 8'h00);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) pass++;
        else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // hold: cycles to keep i_ready low in DONE; early: i_ready high from accept;
    // poke: raise i_valid during BUSY
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         input int hold, input bit early, input bit poke);
        int   g, lat;
        exp_t e;
        g = 0;
        while (!o_ready && g < 20) begin
            tick();
            g++;
        end
        chk("ready_before_req", 32'(o_ready), 32'd1);
        i_a = a; i_b = b; i_sub = sub; i_valid = 1'b1; i_ready = early;
        tick();
        i_valid = 1'b0; i_a = 8'($urandom); i_b = 8'($urandom); i_sub = ~sub;
        sb.push_back(model(a, b, sub));
        lat = 0;
        while (!o_valid && lat < 20) begin
            if (poke && lat == 1) i_valid = 1'b1;
            tick();
            lat++;
            if (poke && lat == 2) begin
                chk("ready_in_busy", 32'(o_ready), 32'd0);
                i_valid = 1'b0;
            end
        end
        i_valid = 1'b0;
        chk("latency", 32'(lat), 32'd4);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("o_s", 32'(o_s), 32'(e.s));
            chk("o_c", 32'(o_c), 32'(e.c));
            chk("o_v", 32'(o_v), 32'(e.v));
            chk("o_n", 32'(o_n), 32'(e.n));
            chk("o_z", 32'(o_z), 32'(e.z));
            if (hold > 0) begin
                repeat (hold) tick();
                chk("hold_valid", 32'(o_valid), 32'd1);
                chk("hold_s", 32'(o_s), 32'(e.s));
            end
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        chk("valid_drop", 32'(o_valid), 32'd0);
        chk("ready_idle", 32'(o_ready), 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; i_valid = 1'b0; i_sub = 1'b0; i_ready = 1'b0; i_a = '0; i_b = '0;
        repeat (2) tick();
        chk("rst_ready", 32'(o_ready), 32'd1);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_flags", {23'd0, o_s, o_c, o_v, o_n, o_z}, 32'd0);
        rst_n = 1'b1;
        tick();

        do_op(8'h05, 8'h03, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h05, 8'h03, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h03, 8'h05, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h7F, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h07, 8'h07, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h00, 8'h80, 1'b1, 0, 1'b0, 1'b0);
        do_op(8'h80, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'hC3, 8'h5A, 1'b0, 3, 1'b0, 1'b0);
        do_op(8'h12, 8'h34, 1'b1, 0, 1'b1, 1'b1);

        // abort mid-BUSY with an asynchronous reset
        i_a = 8'h55; i_b = 8'h22; i_sub = 1'b0; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(o_ready), 32'd1);
        chk("abort_valid", 32'(o_valid), 32'd0);
        chk("abort_outs", {23'd0, o_s, o_c, o_v, o_n, o_z}, 32'd0);
        tick();
        rst_n = 1'b1;
        i_ready = 1'b1;
        repeat (6) tick();
        chk("abort_no_result", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        do_op(8'hFE, 8'h01, 1'b0, 0, 1'b0, 1'b0);
        do_op(8'h81, 8'h02, 1'b1, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
